// File: rtl/lsu_mem_master.sv
// Requester-side load/store unit for a word-addressed data memory.
// Handles one CPU request at a time. Loads that straddle a word boundary
// become two word reads. Misaligned stores become a sequence of byte
// writes. Load data is lane-extracted and then sign- or zero-extended.
module lsu_mem_master #(
  parameter int ADDR_WIDTH        = 32,
  parameter int RAM_ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  input  logic [2:0]                   req_funct3,
  output logic                         resp_valid,
  output logic [DATA_WIDTH-1:0]        resp_rdata,
  output logic                         resp_err,
  output logic [RAM_ADDRESS_WIDTH-1:0] A,
  output logic                         WE,
  output logic [DATA_WIDTH-1:0]        WD,
  output logic [1:0]                   dataType,
  input  logic [DATA_WIDTH-1:0]        RD
);
  localparam int AW = RAM_ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            we_q, mis_q, cross_q, err_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q, w0_q, w1_q;

  // Only the memory-side address bits matter; the upper CPU bits are dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:AW];

  // Access size in bytes from funct3[1:0]: 00 byte, 01 half, else word.
  function automatic logic [2:0] f3_size(input logic [1:0] f);
    case (f)
      2'b00:   f3_size = 3'd1;
      2'b01:   f3_size = 3'd2;
      default: f3_size = 3'd4;
    endcase
  endfunction

  // Request classification on the incoming fields, used at accept.
  logic [2:0] req_size;
  logic       req_cross, req_mis, req_inv, accept;
  always_comb begin
    req_size  = f3_size(req_funct3[1:0]);
    req_cross = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    req_mis   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    if (req_we) req_inv = req_funct3[2] || req_funct3[1:0] == 2'b11;
    else        req_inv = req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                          req_funct3 == 3'b111;
    accept    = req_valid && state_q == S_IDLE;
  end

  // Load result: shift the two captured words down to the addressed byte,
  // then extend from the access size. funct3[2] selects zero-extension.
  logic [2*DW-1:0] ld_sh;
  logic [DW-1:0]   ld_ext;
  logic            sx;
  always_comb begin
    ld_sh = {w1_q, w0_q} >> {addr_q[1:0], 3'b000};
    sx    = !f3_q[2];
    case (f3_q[1:0])
      2'b00:   ld_ext = {{(DW-8){sx & ld_sh[7]}}, ld_sh[7:0]};
      2'b01:   ld_ext = {{(DW-16){sx & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = ld_sh[DW-1:0];
    endcase
  end

  // Next state and memory/response outputs. Everything is forced low while
  // rst_n is asserted so an in-flight write cannot fire during reset.
  logic [2:0] last_cnt;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    A          = '0;
    WE         = 1'b0;
    WD         = '0;
    dataType   = 2'b00;
    last_cnt   = f3_size(f3_q[1:0]) - 3'd1;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        cnt_d     = 3'd0;
        if (req_valid) begin
          if (req_inv)     state_d = S_RESP;
          else if (req_we) state_d = S_WR;
          else             state_d = S_RD0;
        end
      end
      S_RD0: begin
        A       = {addr_q[AW-1:2], 2'b00};
        state_d = cross_q ? S_RD1 : S_RESP;
      end
      S_RD1: begin
        A       = {addr_q[AW-1:2], 2'b00} + AW'(4);
        state_d = S_RESP;
      end
      S_WR: begin
        WE = 1'b1;
        if (mis_q) begin
          A        = addr_q + AW'(cnt_q);
          dataType = 2'b01;
          WD       = {{(DW-8){1'b0}}, wdata_q[cnt_q[1:0]*8 +: 8]};
          if (cnt_q == last_cnt) state_d = S_RESP;
          else                   cnt_d   = cnt_q + 3'd1;
        end else begin
          A       = addr_q;
          WD      = wdata_q;
          case (f3_q[1:0])
            2'b00:   dataType = 2'b01;
            2'b01:   dataType = 2'b10;
            default: dataType = 2'b00;
          endcase
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : ld_ext;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      A          = '0;
      WE         = 1'b0;
      WD         = '0;
      dataType   = 2'b00;
    end
  end

  // State, request capture at accept, and read-data capture in RD0/RD1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        mis_q   <= req_mis;
        cross_q <= req_cross;
        err_q   <= req_inv;
      end
      if (state_q == S_RD0) w0_q <= RD;
      if (state_q == S_RD1) w1_q <= RD;
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-array memory model.
module tb_lsu_mem_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [15:0] A;
  logic        WE;
  logic [31:0] WD;
  logic [1:0]  dataType;
  logic [31:0] RD;

  logic [7:0]  mem [0:65535];

  int n_chk = 0;
  int n_fail = 0;

  // Per-request trace, index k = k-th negedge after the accept edge.
  logic [15:0] la  [0:20];
  logic        lwe [0:20];
  logic [31:0] lwd [0:20];
  logic [1:0]  ldt [0:20];
  int          lat, nwe;
  logic [31:0] rdat;
  logic        rerr;

  lsu_mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .A(A), .WE(WE), .WD(WD), .dataType(dataType), .RD(RD)
  );

  always #5 clk = ~clk;

  // Little-endian word read, 16-bit address wrap.
  always_comb RD = {mem[A + 16'd3], mem[A + 16'd2], mem[A + 16'd1], mem[A]};

  always @(posedge clk) begin
    if (WE) begin
      case (dataType)
        2'b01: mem[A] <= WD[7:0];
        2'b10: begin
          mem[A]         <= WD[7:0];
          mem[A + 16'd1] <= WD[15:8];
        end
        default: begin
          mem[A]         <= WD[7:0];
          mem[A + 16'd1] <= WD[15:8];
          mem[A + 16'd2] <= WD[23:16];
          mem[A + 16'd3] <= WD[31:24];
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3);
    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nwe = 0; rdat = '0; rerr = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      la[k] = A; lwe[k] = WE; lwd[k] = WD; ldt[k] = dataType;
      if (WE) nwe++;
      if (resp_valid) begin
        lat = k; rdat = resp_rdata; rerr = resp_err;
        break;
      end
    end
    if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] outs_packed();
    return {26'd0, req_ready, resp_valid, resp_err, WE, dataType};
  endfunction

  initial begin
    int bad;
    logic [31:0] sw_bytes;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    {mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]} = 32'h8899AABB;
    {mem[16'h0107], mem[16'h0106], mem[16'h0105], mem[16'h0104]} = 32'h11223344;
    {mem[16'hFFFF], mem[16'hFFFE], mem[16'hFFFD], mem[16'hFFFC]} = 32'hCAFEF00D;
    {mem[16'h0003], mem[16'h0002], mem[16'h0001], mem[16'h0000]} = 32'h01234567;
    mem[16'h0303] = 8'hA5;
    mem[16'h0304] = 8'h5A;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", outs_packed(), 32'd0);
    chk("rst_A", {16'd0, A}, 32'd0);
    chk("rst_WD", WD, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    #1 chk("rdy_after_rst", {31'd0, req_ready}, 32'd1);

    // Byte/half/word loads within one word
    run(1'b0, 32'h0000_0101, 32'd0, 3'b000);
    chk("lb_data", rdat, 32'hFFFFFFAA);
    chk("lb_lat", lat, 2);
    chk("lb_A", {16'd0, la[1]}, 32'h0100);
    chk("lb_nwe", nwe, 0);
    run(1'b0, 32'h0000_0101, 32'd0, 3'b100);
    chk("lbu_data", rdat, 32'h000000AA);
    chk("lbu_lat", lat, 2);
    chk("lbu_A", {16'd0, la[1]}, 32'h0100);
    run(1'b0, 32'h0000_0102, 32'd0, 3'b001);
    chk("lh_data", rdat, 32'hFFFF8899);
    chk("lh_nwe", nwe, 0);
    run(1'b0, 32'h0000_0102, 32'd0, 3'b101);
    chk("lhu_data", rdat, 32'h00008899);
    run(1'b0, 32'hABCD_0100, 32'd0, 3'b010);
    chk("lw_data", rdat, 32'h8899AABB);
    chk("lw_lat", lat, 2);
    chk("lw_err", {31'd0, rerr}, 32'd0);

    // Word-crossing loads, including the 16-bit wrap
    run(1'b0, 32'h0000_0103, 32'd0, 3'b010);
    chk("lwx_data", rdat, 32'h22334488);
    chk("lwx_lat", lat, 3);
    chk("lwx_A0", {16'd0, la[1]}, 32'h0100);
    chk("lwx_A1", {16'd0, la[2]}, 32'h0104);
    run(1'b0, 32'h0000_FFFF, 32'd0, 3'b010);
    chk("lwwrap_data", rdat, 32'h234567CA);
    chk("lwwrap_A0", {16'd0, la[1]}, 32'hFFFC);
    chk("lwwrap_A1", {16'd0, la[2]}, 32'h0000);
    run(1'b0, 32'h0000_0103, 32'd0, 3'b001);
    chk("lhx_data", rdat, 32'h00004488);
    chk("lhx_lat", lat, 3);

    // Aligned word store
    run(1'b1, 32'h0000_0200, 32'hDEADBEEF, 3'b010);
    chk("sw_lat", lat, 2);
    chk("sw_nwe", nwe, 1);
    chk("sw_A", {16'd0, la[1]}, 32'h0200);
    chk("sw_dt", {30'd0, ldt[1]}, 32'd0);
    chk("sw_WD", lwd[1], 32'hDEADBEEF);
    chk("sw_rdata", rdat, 32'd0);

    // Misaligned word store: four byte writes, LS byte first
    run(1'b1, 32'h0000_0201, 32'hDEADBEEF, 3'b010);
    chk("swm_lat", lat, 5);
    chk("swm_nwe", nwe, 4);
    sw_bytes = 32'hDEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("swm_A%0d", k), {16'd0, la[k]}, 32'h0200 + k);
      chk($sformatf("swm_WD%0d", k), lwd[k], {24'd0, sw_bytes[7:0]});
      chk($sformatf("swm_dt%0d", k), {30'd0, ldt[k]}, 32'd1);
      sw_bytes = sw_bytes >> 8;
    end
    run(1'b0, 32'h0000_0201, 32'd0, 3'b010);
    chk("swm_readback", rdat, 32'hDEADBEEF);
    chk("swm_rb_lat", lat, 3);

    // Aligned halfword store uses a single halfword write
    run(1'b1, 32'h0000_0206, 32'h0000CAFE, 3'b001);
    chk("sh_lat", lat, 2);
    chk("sh_dt", {30'd0, ldt[1]}, 32'd2);
    chk("sh_A", {16'd0, la[1]}, 32'h0206);

    // Invalid funct3
    run(1'b0, 32'h0000_0100, 32'd0, 3'b011);
    chk("ld_inv_lat", lat, 1);
    chk("ld_inv_err", {31'd0, rerr}, 32'd1);
    chk("ld_inv_rdata", rdat, 32'd0);
    chk("ld_inv_A", {16'd0, la[1]}, 32'd0);
    run(1'b1, 32'h0000_0100, 32'h12345678, 3'b100);
    chk("st_inv_lat", lat, 1);
    chk("st_inv_err", {31'd0, rerr}, 32'd1);
    chk("st_inv_nwe", nwe, 0);
    chk("st_inv_mem", {mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]},
        32'h8899AABB);

    // Reset in the middle of a misaligned store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0301;
    req_wdata = 32'h55667788; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_ctrl", outs_packed(), 32'd0);
    chk("mrst_A", {16'd0, A}, 32'd0);
    chk("mrst_WD", WD, 32'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (WE || resp_valid || req_ready) bad++;
    end
    chk("mrst_quiet", bad, 0);
    rst_n = 1'b1;
    #1 chk("mrst_rdy", {31'd0, req_ready}, 32'd1);
    chk("mrst_b0", {24'd0, mem[16'h0301]}, 32'h88);
    chk("mrst_b1", {24'd0, mem[16'h0302]}, 32'h77);
    chk("mrst_b2", {24'd0, mem[16'h0303]}, 32'hA5);
    chk("mrst_b3", {24'd0, mem[16'h0304]}, 32'h5A);

    run(1'b0, 32'h0000_0101, 32'd0, 3'b000);
    chk("post_rst_lb", rdat, 32'hFFFFFFAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
